// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_REL = 8'hF0;

    // PS/2 uses odd parity across the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a debounce counter; the output level only
// changes after FILTER_LEN consecutive synchronised samples disagree with it.
module ps2_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line,
    output logic level
);

    localparam int            CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Lines idle high, so the synchroniser and level come out of reset at 1.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], line};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frame deserialiser with timeout, plus E0/F0 prefix
// resolution into a single strobe per key event.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 16384
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       extended,
    output logic       released,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int            TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

    logic       clk_lvl;
    logic       clk_lvl_d;
    logic       data_lvl;
    logic       fall;

    ps2_state_t    state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [TW-1:0] t_cnt;
    logic          ext_pend;
    logic          rel_pend;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line    (ps2_clk),
        .level   (clk_lvl)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk_sys (clk_sys),
        .reset   (reset),
        .line    (ps2_data),
        .level   (data_lvl)
    );

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) clk_lvl_d <= 1'b1;
        else       clk_lvl_d <= clk_lvl;
    end

    assign fall = clk_lvl_d & ~clk_lvl;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            t_cnt      <= '0;
            ext_pend   <= 1'b0;
            rel_pend   <= 1'b0;
            code       <= '0;
            extended   <= 1'b0;
            released   <= 1'b0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                t_cnt <= '0;
                if (fall && !data_lvl) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (fall) begin
                // A clock edge always beats a coincident timeout.
                t_cnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {data_lvl, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_lvl;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!data_lvl) begin
                            frame_err <= 1'b1;
                            ext_pend  <= 1'b0;
                            rel_pend  <= 1'b0;
                        end else if (!odd_parity_ok(shreg, par_bit)) begin
                            parity_err <= 1'b1;
                            ext_pend   <= 1'b0;
                            rel_pend   <= 1'b0;
                        end else if (shreg == PS2_EXT) begin
                            ext_pend <= 1'b1;
                        end else if (shreg == PS2_REL) begin
                            rel_pend <= 1'b1;
                        end else begin
                            code     <= shreg;
                            extended <= ext_pend;
                            released <= rel_pend;
                            valid    <= 1'b1;
                            ext_pend <= 1'b0;
                            rel_pend <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (t_cnt == T_MAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                ext_pend  <= 1'b0;
                rel_pend  <= 1'b0;
                shreg     <= '0;
                bit_cnt   <= '0;
            end else begin
                t_cnt <= t_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: directed frame table, hand-written corner sequences and
// randomised key streams checked against a byte-level event model.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 4096;
    localparam int HALF       = 32;
    localparam int K_NONE     = 0;
    localparam int K_VALID    = 1;
    localparam int K_PERR     = 2;
    localparam int K_FERR     = 3;

    logic       clk_sys  = 1'b0;
    logic       reset    = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       extended;
    logic       released;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    always #5 clk_sys = ~clk_sys;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .extended   (extended),
        .released   (released),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        longint     cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        logic       bad_par;
        logic       bad_stop;
        int         kind;
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } vec_t;

    ev_t    got_q[$];
    ev_t    exp_q[$];
    longint cyc       = 0;
    longint fall_cyc  = 0;
    int     multi_cnt = 0;
    int     passed    = 0;
    int     total     = 0;
    logic   m_ext     = 1'b0;
    logic   m_rel     = 1'b0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin : mon
        ev_t e;
        if ((int'(valid) + int'(parity_err) + int'(frame_err)) > 1) multi_cnt++;
        if (valid || parity_err || frame_err) begin
            e.kind = valid ? K_VALID : (parity_err ? K_PERR : K_FERR);
            e.code = code;
            e.ext  = extended;
            e.rel  = released;
            e.cyc  = cyc;
            got_q.push_back(e);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic longint key(input ev_t e);
        if (e.kind == K_VALID) return longint'(e.kind) * 1024 + longint'({e.code, e.ext, e.rel});
        return longint'(e.kind) * 1024;
    endfunction

    // Device-side bit: data set while clock is high, sampled on the falling edge.
    task automatic send_bit(input logic v, input int half);
        @(negedge clk_sys);
        ps2_data = v;
        repeat (half) @(negedge clk_sys);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (half) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int half, output logic busy_mid);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, half);
        busy_mid = busy;
        for (int i = 0; i < 8; i++) send_bit(b[i], half);
        send_bit(par, half);
        send_bit(~bad_stop, half);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    // Byte-level reference: what each received frame should produce.
    task automatic model(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ev_t e;
        e.code = b;
        e.ext  = m_ext;
        e.rel  = m_rel;
        e.cyc  = 0;
        if (bad_stop) begin
            e.kind = K_FERR;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (bad_par) begin
            e.kind = K_PERR;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else begin
            e.kind = K_VALID;
            exp_q.push_back(e);
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    initial begin
        vec_t        tbl[16];
        logic        bm;
        logic [9:0]  last;
        int          lat;

        tbl[0]  = '{8'h1C, 1'b0, 1'b0, K_VALID, 8'h1C, 1'b0, 1'b0};
        tbl[1]  = '{8'hF0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[2]  = '{8'h1C, 1'b0, 1'b0, K_VALID, 8'h1C, 1'b0, 1'b1};
        tbl[3]  = '{8'h1C, 1'b0, 1'b0, K_VALID, 8'h1C, 1'b0, 1'b0};
        tbl[4]  = '{8'hE0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[5]  = '{8'hF0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[6]  = '{8'h75, 1'b0, 1'b0, K_VALID, 8'h75, 1'b1, 1'b1};
        tbl[7]  = '{8'hE0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[8]  = '{8'h1C, 1'b1, 1'b0, K_PERR,  8'h00, 1'b0, 1'b0};
        tbl[9]  = '{8'h2B, 1'b0, 1'b0, K_VALID, 8'h2B, 1'b0, 1'b0};
        tbl[10] = '{8'hF0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[11] = '{8'h5A, 1'b0, 1'b1, K_FERR,  8'h00, 1'b0, 1'b0};
        tbl[12] = '{8'h5A, 1'b0, 1'b0, K_VALID, 8'h5A, 1'b0, 1'b0};
        tbl[13] = '{8'hE1, 1'b0, 1'b0, K_VALID, 8'hE1, 1'b0, 1'b0};
        tbl[14] = '{8'hE0, 1'b0, 1'b0, K_NONE,  8'h00, 1'b0, 1'b0};
        tbl[15] = '{8'h14, 1'b0, 1'b0, K_VALID, 8'h14, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("reset_outputs", {code, extended, released, valid, parity_err, frame_err, busy}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        chk("post_reset_outputs", {code, extended, released, valid, parity_err, frame_err, busy}, 0);

        // Clean 0x1C at a 2206-cycle bit period
        got_q.delete();
        send_frame(8'h1C, 1'b0, 1'b0, 1103, bm);
        chk("slow_busy_mid", bm, 1);
        chk("slow_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("slow_event", key(got_q[0]), K_VALID * 1024 + {8'h1C, 1'b0, 1'b0});
            chk("slow_latency", got_q[0].cyc - fall_cyc, 3 + FILTER_LEN);
        end
        last = {8'h1C, 1'b0, 1'b0};

        // Directed frame table
        for (int i = 0; i < 16; i++) begin
            got_q.delete();
            send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, HALF, bm);
            chk($sformatf("row%0d_busy_mid", i), bm, 1);
            chk($sformatf("row%0d_busy_end", i), busy, 0);
            chk($sformatf("row%0d_count", i), got_q.size(), (tbl[i].kind == K_NONE) ? 0 : 1);
            if (got_q.size() == 1) begin
                chk($sformatf("row%0d_kind", i), got_q[0].kind, tbl[i].kind);
                chk($sformatf("row%0d_latency", i), got_q[0].cyc - fall_cyc, 3 + FILTER_LEN);
                if (tbl[i].kind == K_VALID)
                    chk($sformatf("row%0d_event", i), {got_q[0].code, got_q[0].ext, got_q[0].rel},
                        {tbl[i].code, tbl[i].ext, tbl[i].rel});
            end
            if (tbl[i].kind == K_VALID) last = {tbl[i].code, tbl[i].ext, tbl[i].rel};
            chk($sformatf("row%0d_held", i), {code, extended, released}, last);
        end

        // Clock glitch one sample short of the filter length, with data low
        got_q.delete();
        @(negedge clk_sys);
        ps2_data = 1'b0;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (FILTER_LEN - 1) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("glitch_busy", busy, 0);
        chk("glitch_events", got_q.size(), 0);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk_sys);

        // Timeout after 4 data bits, following a release prefix
        got_q.delete();
        send_frame(8'hF0, 1'b0, 1'b0, HALF, bm);
        send_bit(1'b0, HALF);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h1C >> i), HALF);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("to_busy_before", busy, 1);
        repeat (TIMEOUT + 40) @(negedge clk_sys);
        chk("to_count", got_q.size(), 1);
        if (got_q.size() == 1) begin
            chk("to_kind", got_q[0].kind, K_FERR);
            lat = int'(got_q[0].cyc - fall_cyc);
            chk("to_latency_window",
                (lat >= TIMEOUT + 2 + FILTER_LEN) && (lat <= TIMEOUT + 5 + FILTER_LEN), 1);
        end
        chk("to_busy_after", busy, 0);
        got_q.delete();
        send_frame(8'h1C, 1'b0, 1'b0, HALF, bm);
        chk("to_next_count", got_q.size(), 1);
        if (got_q.size() == 1)
            chk("to_next_event", key(got_q[0]), K_VALID * 1024 + {8'h1C, 1'b0, 1'b0});

        // Reset mid-frame with a release pending
        got_q.delete();
        send_frame(8'hF0, 1'b0, 1'b0, HALF, bm);
        send_bit(1'b0, HALF);
        send_bit(1'b1, HALF);
        send_bit(1'b0, HALF);
        chk("rst_busy_before", busy, 1);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1 chk("rst_outputs", {code, extended, released, valid, parity_err, frame_err, busy}, 0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_sys);
        reset = 1'b0;
        repeat (30) @(negedge clk_sys);
        chk("rst_no_strobe", got_q.size(), 0);
        send_frame(8'h1C, 1'b0, 1'b0, HALF, bm);
        chk("rst_next_count", got_q.size(), 1);
        if (got_q.size() == 1)
            chk("rst_next_event", key(got_q[0]), K_VALID * 1024 + {8'h1C, 1'b0, 1'b0});

        // Randomised key streams against the byte-level model
        got_q.delete();
        exp_q.delete();
        m_ext = 1'b0;
        m_rel = 1'b0;
        for (int i = 0; i < 30; i++) begin
            int         r;
            logic [7:0] b;
            logic       bp;
            logic       bs;
            r  = $urandom_range(0, 99);
            b  = (r < 15) ? 8'hE0 : (r < 30) ? 8'hF0 : 8'($urandom_range(0, 255));
            bp = (r >= 30) && (r < 38);
            bs = (r >= 38) && (r < 42);
            model(b, bp, bs);
            send_frame(b, bp, bs, $urandom_range(16, 40), bm);
        end
        chk("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rand_ev%0d", i), key(got_q[i]), key(exp_q[i]));

        chk("single_strobe", multi_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

PS/2 keyboard receiver for the Lynx core. It deserialises the clock/data pair driven by the HPS keyboard emulation (`ps2[0]` = clock, `ps2[1]` = data) into scan-code bytes. It resolves the `E0` (extended) and `F0` (release) prefixes into flags and emits one strobe per key event. The Lynx keyboard matrix logic consumes that strobe. The block sits inside the core on `clk_sys`, on the far side of the PS/2 link that `hps_io` transmits.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical synchronised samples required before a line level change is accepted.
- `TIMEOUT`, 16384: `clk_sys` cycles allowed between falling clock edges inside a frame before the frame is abandoned.

Ports:
- `clk_sys` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk` in 1: PS/2 clock line, asynchronous to `clk_sys`.
- `ps2_data` in 1: PS/2 data line, asynchronous to `clk_sys`.
- `code` out 8: last decoded non-prefix scan code.
- `extended` out 1: the `code` byte was preceded by `E0`.
- `released` out 1: the `code` byte was preceded by `F0`.
- `valid` out 1: one-cycle strobe; `code`, `extended` and `released` are new this cycle.
- `parity_err` out 1: one-cycle strobe on an odd-parity failure.
- `frame_err` out 1: one-cycle strobe on a bad stop bit or a timeout.
- `busy` out 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- **Line conditioning.** Each line passes through a 2-flop synchroniser and then a FILTER_LEN debounce counter.
  - The filtered clock falls when FILTER_LEN consecutive samples read 0 after a filtered 1.
  - That event produces one-cycle `fall`.
  - Data is sampled from the filtered data line on `fall`.
- **Frame format:** 11 bits. Start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data 0, go to DATA with bit count 0. On `fall` with data 1, stay in IDLE (spurious edge, no error).
  - DATA: on each `fall`, shift data into bit [7] of the shift register (right shift). After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on `fall`, evaluate the frame and return to IDLE.
    - Stop bit 0: pulse `frame_err`.
    - Stop bit 1 and XOR of the 8 data bits and the parity bit ≠ 1: pulse `parity_err`.
    - Otherwise the byte is good.
- **Timeout.** In any state other than IDLE, the counter is cleared on every `fall`. When it reaches TIMEOUT, return to IDLE, pulse `frame_err`, and discard the partial byte.
- **Prefix layer**, applied to good bytes only:
  - `E0`: set `ext_pend`. No `valid`.
  - `F0`: set `rel_pend`. No `valid`.
  - Any other byte, including `E1`:
    - `code` ← byte.
    - `extended` ← `ext_pend`, `released` ← `rel_pend`.
    - Pulse `valid` and clear both pendings.
- Any `parity_err` or `frame_err` clears both pendings.
- `code`, `extended` and `released` hold their value until the next `valid`.

## Timing
- **Reset values:** all outputs 0. State IDLE. Shift register, bit count, timeout counter, pendings and filter states all 0; the filtered lines reset to 1 (idle-high).
- **Reset mid-frame:** asynchronous return to reset values in the same cycle; no strobe is emitted.
- **Edge latency:** raw falling clock to `fall` is 2 + FILTER_LEN cycles.
- **Output latency:** `valid`, `parity_err` and `frame_err` assert exactly 1 cycle after the STOP-state `fall`, or the timeout terminal cycle. They are registered and last exactly 1 cycle.
- At most one of `valid`, `parity_err`, `frame_err` is high in any cycle.
- `busy` rises 1 cycle after the start-bit `fall` and falls in the same cycle as the result strobe.
- **Simultaneous `fall` and timeout terminal count:** `fall` wins and the counter clears.
- **Width rules:**
  - The timeout counter is $clog2(TIMEOUT+1) bits and saturates.
  - The filter counter is $clog2(FILTER_LEN) bits.
  - The bit count is 3 bits.

## Structure
- **Package `ps2_pkg`:**
  - state enum `ps2_state_t` {IDLE, DATA, PARITY, STOP};
  - localparams `PS2_EXT` = 8'hE0, `PS2_REL` = 8'hF0.
- **Sub-module `ps2_filter`:** synchroniser plus debounce, parameter FILTER_LEN, output `level`. It is instantiated twice (clock, data). The top-level block derives `fall` from the clock instance.
- Frame FSM, timeout counter and prefix layer live in `ps2_rx`.

## Test plan
- Clean frame for 0x1C (parity bit 0) at a 2206-cycle bit period → one `valid`, `code`=1C, `extended`=0, `released`=0, no error strobes.
- `F0`, then `1C` → exactly one `valid`, `code`=1C, `released`=1. A following `1C` → `released`=0.
- `E0`, `F0`, `75` → a single `valid`, `code`=75, `extended`=1, `released`=1.
- 0x1C sent with parity bit 1 → `parity_err` pulse, no `valid`, pendings cleared. The next good `2B` frame → `valid`, `code`=2B.
- Frame aborted after 4 data bits, line idle for TIMEOUT+1 cycles → one `frame_err`, `busy`=0. The next `1C` decodes correctly.
- Clock glitch low for FILTER_LEN−1 cycles → no state change. `reset` asserted mid-frame → all outputs 0 immediately, and a subsequent clean frame decodes.
